// File: rtl/lab1_sweep_pkg.sv
// rtl/lab1_sweep_pkg.sv - shared state encoding and default parameters for the Lab1 sweep controller.
package lab1_sweep_pkg;

  localparam int N_IN_DEF       = 4;
  localparam int SETTLE_CYC_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

endpackage

// File: rtl/lab1_settle_timer.sv
// rtl/lab1_settle_timer.sv - 8-bit loadable down-counter; expire flags the last settle cycle.
module lab1_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiry at 1 (not 0) so a load of N yields exactly N cycles in SETTLE.
  assign expire = (cnt_q == 8'd1);

endmodule

// File: rtl/lab1_sweep_ctrl.sv
// rtl/lab1_sweep_ctrl.sv - exhaustive truth-table sweep of the Lab1 function with expected-table compare.
// Optional SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching code.
module lab1_sweep_ctrl
  import lab1_sweep_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TW         = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [TW-1:0]   expect_tt,
  output logic [N_IN-1:0] abcd,
  input  logic            f_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [TW-1:0]   tt,
  output logic [N_IN-1:0] fail_idx,
  output logic [N_IN:0]   fail_cnt
);

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [N_IN-1:0] abcd_q, abcd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [TW-1:0]   tt_q, tt_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;
  logic [N_IN:0]   fail_cnt_q, fail_cnt_d;
  logic            tmr_load, tmr_en, tmr_expire;
  logic            mismatch;

  lab1_settle_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (8'(SETTLE_CYC)),
    .expire   (tmr_expire)
  );

  assign mismatch = (f_in != exp_q[idx_q]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    abcd_d     = abcd_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    tt_d       = tt_q;
    exp_d      = exp_q;
    fail_idx_d = fail_idx_q;
    fail_cnt_d = fail_cnt_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          exp_d      = expect_tt;
          tt_d       = '0;
          fail_cnt_d = '0;
          fail_idx_d = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        abcd_d   = idx_q;
        tmr_load = 1'b1;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_expire) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        tt_d[idx_q] = f_in;
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (fail_cnt_q == '0) begin
            fail_idx_d = idx_q;
          end
        end
`ifdef SWEEP_STOP_ON_FAIL_EN
        if (mismatch || idx_q == N_IN'(TW - 1)) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
`else
        if (idx_q == N_IN'(TW - 1)) begin
          state_d = ST_FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_DRIVE;
        end
`endif
      end
      ST_FIN: begin
        // fail_cnt_q already includes the final sample's result here.
        done_d  = 1'b1;
        busy_d  = 1'b1;
        pass_d  = (fail_cnt_q == '0);
        abcd_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      abcd_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tt_q       <= '0;
      exp_q      <= '0;
      fail_idx_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      abcd_q     <= abcd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tt_q       <= tt_d;
      exp_q      <= exp_d;
      fail_idx_q <= fail_idx_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign abcd     = abcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign tt       = tt_q;
  assign fail_idx = fail_idx_q;
  assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_lab1_sweep_ctrl.sv
// tb/tb_lab1_sweep_ctrl.sv - directed and randomized sweeps against a truth-table reference model.
// Honours SWEEP_STOP_ON_FAIL_EN in the reference model.
module tb_lab1_sweep_ctrl;

  localparam int N  = 4;
  localparam int S  = 3;
  localparam int TW = 16;
  localparam int SP = S + 2;
`ifdef SWEEP_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [TW-1:0] expect_tt = '0;
  logic [N-1:0]  abcd;
  logic          f_in;
  logic          busy, done, pass;
  logic [TW-1:0] tt;
  logic [N-1:0]  fail_idx;
  logic [N:0]    fail_cnt;
  logic [TW-1:0] f_tbl = '0;

  int tests = 0;
  int fails = 0;

  lab1_sweep_ctrl #(.N_IN(N), .SETTLE_CYC(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .expect_tt (expect_tt),
    .abcd      (abcd),
    .f_in      (f_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .tt        (tt),
    .fail_idx  (fail_idx),
    .fail_cnt  (fail_cnt)
  );

  assign f_in = f_tbl[abcd];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_abcd"}, 32'(abcd), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_tt"}, 32'(tt), 32'd0);
    check({tag, "_fidx"}, 32'(fail_idx), 32'd0);
    check({tag, "_fcnt"}, 32'(fail_cnt), 32'd0);
  endtask

  // Reference: walk codes in order, compare against the table latched at start.
  task automatic model(input logic [TW-1:0] f, input logic [TW-1:0] e,
                       output logic [TW-1:0] m_tt, output int m_cnt, output int m_idx,
                       output int m_done_k);
    int last;
    m_tt = '0; m_cnt = 0; m_idx = 0; last = TW - 1;
    for (int i = 0; i < TW; i++) begin
      m_tt[i] = f[i];
      if (f[i] != e[i]) begin
        if (m_cnt == 0) m_idx = i;
        m_cnt++;
        if (STOP) begin
          last = i;
          break;
        end
      end
    end
    m_done_k = (last + 1) * SP + 1;
  endtask

  task automatic run_sweep(input string tag, input logic [TW-1:0] f, input logic [TW-1:0] e,
                           input int poke);
    logic [TW-1:0] m_tt;
    int m_cnt, m_idx, m_done_k;
    int k, done_k, seq_err, busy_err, exp_abcd;
    bit poked;
    model(f, e, m_tt, m_cnt, m_idx, m_done_k);
    f_tbl = f;
    expect_tt = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; done_k = -1; seq_err = 0; busy_err = 0; poked = 1'b0;
    while (k <= 200) begin
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
      exp_abcd = (k == 0) ? 0 : (k - 1) / SP;
      if (32'(abcd) != 32'(exp_abcd)) seq_err++;
      expect_tt = TW'($urandom);
      if (poke >= 0 && !poked && 32'(abcd) == 32'(poke)) begin
        start = 1'b1;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({tag, "_done_lat"}, 32'(done_k), 32'(m_done_k));
    check({tag, "_pass"}, 32'(pass), 32'(m_cnt == 0));
    check({tag, "_tt"}, 32'(tt), 32'(m_tt));
    check({tag, "_fcnt"}, 32'(fail_cnt), 32'(m_cnt));
    check({tag, "_fidx"}, 32'(fail_idx), 32'(m_idx));
    check({tag, "_abcd_fin"}, 32'(abcd), 32'd0);
    check({tag, "_abcd_seq_err"}, 32'(seq_err), 32'd0);
    check({tag, "_busy_err"}, 32'(busy_err), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold_tt"}, 32'(tt), 32'(m_tt));
  endtask

  initial begin
    int n;
    bit seen_done;
    logic [TW-1:0] rf, rm;

    #1;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_sweep("parity_ok", 16'h6996, 16'h6996, -1);
    run_sweep("parity_bit0", 16'h6996, 16'h6997, -1);
    run_sweep("all_zero", 16'h0000, 16'hFFFF, -1);
    run_sweep("start_busy", 16'h6996, 16'h6996, 5);
    run_sweep("stop_case", 16'h6996, 16'h6986, -1);

    // Abort mid-sweep with reset at code 7.
    f_tbl = 16'h6996;
    expect_tt = 16'h6996;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (abcd !== 4'd7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach_code7", 32'(abcd), 32'd7);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    check("rst_idle_busy", 32'(busy), 32'd0);
    run_sweep("after_rst", 16'h6996, 16'h6996, -1);

    for (int r = 0; r < 6; r++) begin
      rf = TW'($urandom);
      case (r % 3)
        0: rm = '0;
        1: rm = TW'(1) << $urandom_range(TW - 1);
        default: rm = TW'($urandom) & TW'($urandom);
      endcase
      run_sweep($sformatf("rand%0d", r), rf, rf ^ rm, (r == 4) ? int'($urandom_range(TW - 1)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
